tdm_demux4: RTL

- Receive end of the 4-channel time-division link whose transmit side round-robins four channel bits onto one serial line through a 4:1 select.
- Locks to the frame marker, routes each serial sample back to its channel, holds the latest bit per channel, and deserializes each channel into WIDTH-bit words, MSB first.
- Sits between the serial link pins and the per-channel consumers.

---
 rtl/tdm_demux4_pkg.sv | 22 ++
 rtl/tdm_ch_shift.sv | 24 ++
 rtl/tdm_demux4.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared TDM link definitions (slot count, slot index width, framer state codes)
// used by both ends of the link, plus small slot arithmetic helpers.
package tdm_demux4_pkg;

    localparam int TDM_SLOTS  = 4;
    localparam int TDM_SLOT_W = 2;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef logic [TDM_SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_FIRST = slot_t'(0);
    localparam slot_t SLOT_LAST  = slot_t'(TDM_SLOTS - 1);

    function automatic slot_t next_slot(input slot_t s);
        return s + slot_t'(1);
    endfunction

endpackage

// File: rtl/tdm_ch_shift.sv
// Per-channel MSB-first deserializer. A clear coinciding with a shift loads
// the incoming bit into an otherwise empty register (realign-and-accept).
module tdm_ch_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= shift ? {{(WIDTH-1){1'b0}}, din} : '0;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4-channel TDM link: frame lock, slot routing, per-channel
// latest bit and WIDTH-bit word assembly.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame_sync,
    input  logic             din,
    output logic [3:0]       ch_bit,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err,
    output logic [WIDTH-1:0] word_out,
    output logic [1:0]       word_ch,
    output logic             word_valid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    slot_t            slot_q, slot_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [3:0]       ch_bit_q, ch_bit_d;
    logic             sync_err_q, sync_err_d;
    logic [WIDTH-1:0] word_out_q, word_out_d;
    slot_t            word_ch_q, word_ch_d;
    logic             word_valid_q, word_valid_d;

    logic             accept;
    logic             clr_all;
    slot_t            acc_slot;
    logic [CW-1:0]    bc_use;
    logic [WIDTH-1:0] sh_cur;
    logic [WIDTH-1:0] sh_q [TDM_SLOTS];
    logic [TDM_SLOTS-1:0] shift_en;

    for (genvar i = 0; i < TDM_SLOTS; i++) begin : g_ch
        assign shift_en[i] = accept && (acc_slot == slot_t'(i));

        tdm_ch_shift #(.WIDTH(WIDTH)) u_shift (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr_all),
            .shift (shift_en[i]),
            .din   (din),
            .q     (sh_q[i])
        );
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        bitcnt_d     = bitcnt_q;
        ch_bit_d     = ch_bit_q;
        sync_err_d   = 1'b0;
        word_out_d   = word_out_q;
        word_ch_d    = word_ch_q;
        word_valid_d = 1'b0;
        accept       = 1'b0;
        clr_all      = 1'b0;
        acc_slot     = slot_q;
        bc_use       = bitcnt_q;
        sh_cur       = '0;

        if (en) begin
            case (state_q)
                ST_HUNT: begin
                    if (frame_sync) begin
                        accept   = 1'b1;
                        clr_all  = 1'b1;
                        acc_slot = SLOT_FIRST;
                        bc_use   = '0;
                        state_d  = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (slot_q == SLOT_FIRST && !frame_sync) begin
                        sync_err_d = 1'b1;
                        clr_all    = 1'b1;
                        state_d    = ST_HUNT;
                        slot_d     = SLOT_FIRST;
                        bitcnt_d   = '0;
                    end else if (slot_q != SLOT_FIRST && frame_sync) begin
                        // Early marker: realign so this sample starts a fresh frame 0.
                        sync_err_d = 1'b1;
                        clr_all    = 1'b1;
                        accept     = 1'b1;
                        acc_slot   = SLOT_FIRST;
                        bc_use     = '0;
                    end else begin
                        accept = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (accept) begin
            sh_cur             = clr_all ? '0 : sh_q[acc_slot];
            ch_bit_d[acc_slot] = din;
            if (bc_use == BIT_LAST) begin
                word_out_d   = {sh_cur[WIDTH-2:0], din};
                word_ch_d    = acc_slot;
                word_valid_d = 1'b1;
            end
            slot_d = next_slot(acc_slot);
            if (acc_slot == SLOT_LAST) begin
                bitcnt_d = (bc_use == BIT_LAST) ? '0 : bc_use + 1'b1;
            end else begin
                bitcnt_d = bc_use;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            slot_q       <= SLOT_FIRST;
            bitcnt_q     <= '0;
            ch_bit_q     <= '0;
            sync_err_q   <= 1'b0;
            word_out_q   <= '0;
            word_ch_q    <= SLOT_FIRST;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            bitcnt_q     <= bitcnt_d;
            ch_bit_q     <= ch_bit_d;
            sync_err_q   <= sync_err_d;
            word_out_q   <= word_out_d;
            word_ch_q    <= word_ch_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign ch_bit     = ch_bit_q;
    assign slot       = slot_q;
    assign locked     = (state_q == ST_LOCKED);
    assign sync_err   = sync_err_q;
    assign word_out   = word_out_q;
    assign word_ch    = word_ch_q;
    assign word_valid = word_valid_q;

endmodule
